rv32m_muldiv_unit: RTL and testbench
====================================

// Module: rv32m_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the execute stage, beside the integer ALU.
//  Accepts one M-extension operation per start pulse.
//  Computes it over a fixed multi-cycle sequence.
//  Drives busy to pipeline control, which raises ExREGstall/Exnow while busy=1.
//  Presents a registered 32-bit result, qualified by a one-cycle done pulse.
// PARAMETERS
//  WIDTH   32   operand/result width; iteration count = WIDTH (only 32 is supported)
// PORTS
//  clk      in   1      system clock, all state updates on rising edge
//  reset    in   1      synchronous, active-high; one clock, one reset domain
//  start    in   1      launch operation; sampled only in IDLE
//  flush    in   1      abort in-flight operation (ExREGclear)
//  funct3   in   3      000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  opa      in   WIDTH  rs1 value, captured with start
//  opb      in   WIDTH  rs2 value, captured with start
//  busy     out  1      operation in progress (CALC or FIX)
//  done     out  1      one-cycle pulse; result valid this cycle
//  result   out  WIDTH  final value; held until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; busy=0; done=0; result=0; internal accumulators cleared.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   - IDLE & start & !flush: capture funct3 and operand magnitudes.
//     Record the sign flags for the signed ops.
//     Normal op goes to CALC with count=0.
//     Special case goes straight to DONE.
//   - CALC: one radix-2 step per cycle; count 0..WIDTH-1.
//     Mul: shift-add into a 2*WIDTH product.
//     Div: restoring shift-subtract.
//     After count=WIDTH-1, go to FIX.
//   - FIX: apply the sign correction.
//     Select the low/high product half, or the quotient/remainder, into result.
//     Then go to DONE.
//   - DONE: done=1 for exactly one cycle, then IDLE; a start in DONE is ignored.
//  Latency: start is high in cycle 0.
//   - CALC occupies cycles 1..32; FIX is cycle 33; DONE (done=1) is cycle 34.
//   - busy=1 in cycles 1..33; busy=0 in IDLE and DONE.
//  Special cases (done in cycle 1, busy never asserted):
//   - divisor=0: DIV/DIVU give all ones; REM/REMU give opa.
//   - DIV/REM with opa=0x80000000, opb=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
//  Sign rules:
//   - MULH: both operands signed.
//   - MULHSU: opa signed, opb unsigned.
//   - Quotient sign = sign(opa) XOR sign(opb).
//   - Remainder sign = sign(opa).
//   - Negation is two's-complement, at WIDTH or 2*WIDTH as appropriate.
//  Arithmetic: the product uses a 2*WIDTH register; the divider uses a WIDTH+1 bit partial remainder.
//  Start while busy: ignored; operands are not re-captured.
//  flush in any state: next state IDLE, busy=0, done=0; result keeps its previous value.
//  flush with start in the same cycle: flush wins; the operation is not accepted.
//  reset mid-operation: same as the reset values above; no done pulse.
//  result changes only on the FIX->DONE edge or the special-case capture edge.
// TESTING
//  MUL 7 x -3 (opb=0xFFFFFFFD): result=0xFFFFFFEB, done in cycle 34, busy cycles 1..33.
//  MULH/MULHSU/MULHU, opa=opb=0x80000000: results 0x40000000 / 0xC0000000 / 0x40000000.
//  DIV -7/2, then REM -7/2: 0xFFFFFFFD, then 0xFFFFFFFF; DIVU 100/7=14, REMU 100/7=2.
//  DIVU 5/0 gives 0xFFFFFFFF; REM 5/0 gives 5; DIV 0x80000000/-1 gives 0x80000000; all with done in cycle 1.
//  flush in cycle 10 of a DIV: busy=0 from cycle 11, no done pulse, result unchanged.
//  Then a new MUL 3x4 gives 12 with normal latency.
//  start pulses in cycles 1..33 are ignored; reset in cycle 20: busy=0, done=0, result=0 next cycle.

Source files
------------

// File: rtl/rv32m_muldiv_unit.sv
// rv32m_muldiv_unit: iterative RV32M multiply/divide unit with busy/done handshake
module rv32m_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  state_t r_state, w_next;
  logic [2:0]     r_op;
  logic           r_neg;
  logic [W-1:0]   r_a, r_b, r_quo, r_rem, r_result;
  logic [2*W-1:0] r_prod;
  logic [CW-1:0]  r_cnt;
  logic           w_is_div, w_a_neg, w_b_neg, w_neg, w_div0, w_ovf, w_special, w_accept, w_ge;
  logic [W-1:0]   w_a_mag, w_b_mag, w_special_res, w_fix;
  logic [W:0]     w_sum, w_shift, w_diff;
  logic [2*W-1:0] w_mul_next, w_p;
  always_comb begin
    w_is_div      = i_funct3[2];
    w_a_neg       = i_opa[W-1] & (i_funct3 == 3'b001 || i_funct3 == 3'b010 || i_funct3 == 3'b100 || i_funct3 == 3'b110);
    w_b_neg       = i_opb[W-1] & (i_funct3 == 3'b001 || i_funct3 == 3'b100 || i_funct3 == 3'b110);
    w_a_mag       = w_a_neg ? -i_opa : i_opa;
    w_b_mag       = w_b_neg ? -i_opb : i_opb;
    w_neg         = (w_is_div && i_funct3[1]) ? w_a_neg : w_a_neg ^ w_b_neg;
    w_div0        = w_is_div && i_opb == '0;
    w_ovf         = w_is_div && !i_funct3[0] && i_opa == {1'b1, {(W-1){1'b0}}} && i_opb == '1;
    w_special     = w_div0 || w_ovf;
    // Divide-by-zero returns all ones / dividend; signed overflow returns dividend / zero.
    w_special_res = w_div0 ? (i_funct3[1] ? i_opa : '1) : (i_funct3[1] ? '0 : i_opa);
    w_accept      = r_state == S_IDLE && i_start && !i_flush;
  end
  always_comb begin
    w_sum      = {1'b0, r_prod[2*W-1:W]} + {1'b0, r_a};
    w_mul_next = r_prod[0] ? {w_sum, r_prod[W-1:1]} : {1'b0, r_prod[2*W-1:1]};
    w_shift    = {r_rem, r_quo[W-1]};
    w_ge       = w_shift >= {1'b0, r_b};
    w_diff     = w_shift - {1'b0, r_b};
    w_p        = r_neg ? -r_prod : r_prod;
    w_fix      = r_op[2] ? (r_op[1] ? (r_neg ? -r_rem : r_rem) : (r_neg ? -r_quo : r_quo))
                         : (r_op[1:0] == 2'b00 ? w_p[W-1:0] : w_p[2*W-1:W]);
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end
  always_comb begin
    w_next = i_flush                ? S_IDLE
           : r_state == S_IDLE      ? (w_accept ? (w_special ? S_DONE : S_CALC) : S_IDLE)
           : r_state == S_CALC      ? (r_cnt == CW'(W-1) ? S_FIX : S_CALC)
           : r_state == S_FIX       ? S_DONE
           :                          S_IDLE;
  end
  always_comb begin
    o_busy   = r_state == S_CALC || r_state == S_FIX;
    o_done   = r_state == S_DONE;
    o_result = r_result;
  end
  // Both the multiply and divide datapaths step every CALC cycle; FIX picks the one the op needs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op     <= i_funct3;
      r_neg    <= w_neg;
      r_a      <= w_a_mag;
      r_b      <= w_b_mag;
      r_quo    <= w_a_mag;
      r_rem    <= '0;
      r_prod   <= {{W{1'b0}}, w_b_mag};
      r_cnt    <= '0;
      r_result <= w_special ? w_special_res : r_result;
    end else if (r_state == S_CALC && !i_flush) begin
      r_cnt    <= r_cnt + 1'b1;
      r_prod   <= w_mul_next;
      r_rem    <= w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
      r_quo    <= {r_quo[W-2:0], w_ge};
    end else if (r_state == S_FIX && !i_flush) begin
      r_result <= w_fix;
    end
  end
endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// tb_rv32m_muldiv_unit: directed vectors checked against a cycle-level behavioural model
module tb_rv32m_muldiv_unit;
  logic        clk = 0, reset = 1, start = 0, flush = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] opa = 0, opb = 0;
  logic        busy, done;
  logic [31:0] result;
  int n_chk = 0, n_fail = 0;
  bit chk_on = 0;
  int m_cyc = 0;
  logic [31:0] m_res = 0, m_exp = 0;

  rv32m_muldiv_unit #(.WIDTH(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_flush(flush), .i_funct3(funct3),
    .i_opa(opa), .i_opb(opb), .o_busy(busy), .o_done(done), .o_result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] p;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: return b == 0 ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  // m_cyc: 0 idle, 1..33 working, 34 done pulse
  always @(posedge clk) begin
    if (reset) begin
      m_cyc <= 0;
      m_res <= 0;
    end else if (flush) begin
      m_cyc <= 0;
    end else if (m_cyc == 0) begin
      if (start) begin
        m_exp <= ref_res(funct3, opa, opb);
        m_cyc <= special(funct3, opa, opb) ? 34 : 1;
        if (special(funct3, opa, opb)) m_res <= ref_res(funct3, opa, opb);
      end
    end else if (m_cyc == 34) begin
      m_cyc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_cyc == 33) m_res <= m_exp;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_busy", {31'b0, busy}, {31'b0, m_cyc >= 1 && m_cyc <= 33});
      chk("model_done", {31'b0, done}, {31'b0, m_cyc == 34});
      chk("model_result", result, m_res);
    end
  end

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1; funct3 = f; opa = a; opb = b;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input int lat);
    int n = 0;
    launch(f, a, b);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        n = c;
        break;
      end
    end
    chk({nm, "_latency"}, n, lat);
    chk(nm, result, exp);
  endtask

  initial begin
    int cnt;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk_on = 1;
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    chk("reset_result", result, 0);

    // MUL 7 x -3 with start held high through cycles 1..33 using different operands
    @(posedge clk); #1;
    start = 1; funct3 = 3'd0; opa = 7; opb = 32'hFFFFFFFD;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      opa = 99; opb = 5; funct3 = 3'd4;
      if (c == 1) begin
        @(negedge clk);
        chk("mul_busy_c1", {31'b0, busy}, 1);
      end
    end
    @(negedge clk);
    chk("mul_busy_c33", {31'b0, busy}, 1);
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("mul_done_c34", {31'b0, done}, 1);
    chk("mul_busy_c34", {31'b0, busy}, 0);
    chk("mul_7x-3", result, 32'hFFFFFFEB);

    op("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    op("mulhsu", 3'd2, 32'h80000000, 32'h80000000, 32'hC0000000, 34);
    op("mulhu", 3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    op("mulhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    op("mulh_m1", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
    op("div_-7/2", 3'd4, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 34);
    op("rem_-7/2", 3'd6, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 34);
    op("div_7/-2", 3'd4, 7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    op("rem_7/-2", 3'd6, 7, 32'hFFFFFFFE, 32'h00000001, 34);
    op("divu_100/7", 3'd5, 100, 7, 14, 34);
    op("remu_100/7", 3'd7, 100, 7, 2, 34);
    op("divu_5/0", 3'd5, 5, 0, 32'hFFFFFFFF, 1);
    op("rem_5/0", 3'd6, 5, 0, 5, 1);
    op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 0, 1);
    op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

    // Flush a DIV in cycle 10
    launch(3'd4, 1000, 3);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    chk("flush_busy_c11", {31'b0, busy}, 0);
    cnt = 0;
    repeat (30) begin @(negedge clk); cnt += int'(done); end
    chk("flush_no_done", cnt, 0);
    chk("flush_result_kept", result, 32'h80000000);

    op("mul_3x4", 3'd0, 3, 4, 12, 34);

    // start and flush together: not accepted
    @(posedge clk); #1;
    start = 1; flush = 1; funct3 = 3'd0; opa = 5; opb = 5;
    @(posedge clk); #1;
    start = 0; flush = 0;
    @(negedge clk);
    chk("start_flush_busy", {31'b0, busy}, 0);
    chk("start_flush_result", result, 12);

    // Reset in cycle 20 of a MULHU
    launch(3'd3, 32'hDEADBEEF, 32'h12345678);
    repeat (19) begin @(posedge clk); #1; end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rst_mid_busy", {31'b0, busy}, 0);
    chk("rst_mid_done", {31'b0, done}, 0);
    chk("rst_mid_result", result, 0);
    cnt = 0;
    repeat (20) begin @(negedge clk); cnt += int'(done); end
    chk("rst_mid_no_done", cnt, 0);

    op("mulhu_after_rst", 3'd3, 32'hDEADBEEF, 32'h12345678, 32'h0FD5BDEE, 34);

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
